retire_stage: RTL and testbench

- In-order retire (IR) stage of the R10K-style out-of-order core.
- Consumes the head-of-ROB retire packet and drives ir_stall back to the ROB.
- Commits state:
  - updates the architectural map table (AMT);
  - returns the previous physical tag to the free list;
  - commits stores through a req/ack handshake with the store buffer;
  - stops the core on halt.
- Exports the AMT for map-table recovery, plus a retire trace for the bench.

---
 rtl/retire_stage_pkg.sv | 37 +++
 rtl/retire_stage_if.sv | 27 ++
 rtl/retire_stage_arch_map_table.sv | 33 +++
 rtl/retire_stage.sv | 182 ++++++++++++++++++
 tb/tb_retire_stage.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/retire_stage_pkg.sv
// Shared types for the in-order retire stage: ROB head packet, free-list
// packet and the retire FSM state encoding.
package retire_stage_pkg;

    localparam int XLEN   = 32;
    localparam int TAG_W  = 6;
    localparam int INST_W = 32;
    // Destination register field position inside the instruction word.
    localparam int RD_LSB = 7;

    typedef logic [TAG_W-1:0]  TAG;
    typedef logic [INST_W-1:0] INST;

    typedef struct packed {
        logic            retire_en;
        TAG              retire_t;
        TAG              retire_t_old;
        INST             inst;
        logic            halt;
        logic            wr_mem;
        logic            has_dest_reg;
        logic [XLEN-1:0] NPC;
        logic            take_branch;
    } ROB_IR_PACKET;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        ST_WAIT = 2'd1,
        HALTED  = 2'd2
    } IR_STATE;

    typedef struct packed {
        logic free_en;
        TAG   free_tag;
    } IR_FREE_PACKET;

endpackage

// File: rtl/retire_stage_if.sv
// Handshake bundle between the ROB head / store buffer (master side) and
// the retire stage (slave side).
interface retire_stage_if;
    import retire_stage_pkg::*;

    ROB_IR_PACKET    rob_ir_packet;
    logic            st_commit_ack;
    logic            ir_stall;
    logic            free_en;
    TAG              free_tag;
    logic            st_commit_req;
    logic            retire_valid;
    logic [XLEN-1:0] retire_NPC;
    INST             retire_inst;

    modport master (
        output rob_ir_packet, st_commit_ack,
        input  ir_stall, free_en, free_tag, st_commit_req,
               retire_valid, retire_NPC, retire_inst
    );

    modport slave (
        input  rob_ir_packet, st_commit_ack,
        output ir_stall, free_en, free_tag, st_commit_req,
               retire_valid, retire_NPC, retire_inst
    );
endinterface

// File: rtl/retire_stage_arch_map_table.sv
// Architectural map table: one TAG per architectural register, identity
// mapping after reset, one write port, every entry visible in parallel.
module arch_map_table
    import retire_stage_pkg::*;
#(
    parameter int NUM_ARCH_REG = 32,
    parameter int AW           = $clog2(NUM_ARCH_REG)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_idx,
    input  TAG            wr_tag,
    output TAG            map [NUM_ARCH_REG]
);

    TAG map_reg [NUM_ARCH_REG];

    for (genvar gi = 0; gi < NUM_ARCH_REG; gi++) begin : g_entry
        // Entry gi: identity on reset, overwritten by a retiring writer of
        // register gi; readers see the old value until the edge.
        always_ff @(posedge clock) begin
            if (reset) begin
                map_reg[gi] <= TAG'(gi);
            end else if (wr_en && (wr_idx == AW'(gi))) begin
                map_reg[gi] <= wr_tag;
            end
        end

        assign map[gi] = map_reg[gi];
    end

endmodule

// File: rtl/retire_stage.sv
// In-order retire stage: commits the ROB head, updates the AMT, frees the
// previous physical tag, holds stores until the store buffer accepts them
// and stops the core on halt.
module retire_stage
    import retire_stage_pkg::*;
#(
    parameter int NUM_ARCH_REG = 32,
    parameter int CNT_W        = 64
) (
    input  logic             clock,
    input  logic             reset,
    retire_stage_if.slave    ir,
    output TAG               arch_map [NUM_ARCH_REG],
    output logic             halted,
    output logic [CNT_W-1:0] retired_cnt
);

    localparam int AW = $clog2(NUM_ARCH_REG);

    IR_STATE          state_reg;
    TAG               lat_t_reg;
    TAG               lat_t_old_reg;
    logic             lat_has_dest_reg;
    INST              lat_inst_reg;
    logic [XLEN-1:0]  lat_npc_reg;
    logic             halted_reg;
    logic [CNT_W-1:0] retired_cnt_reg;

    TAG              src_t;
    TAG              src_t_old;
    logic            src_has_dest;
    INST             src_inst;
    logic [XLEN-1:0] src_npc;
    logic            retire_now;
    logic            halt_now;
    logic            stall_now;
    logic            req_now;
    logic            amt_wr_en;
    logic [AW-1:0]   amt_wr_idx;
    IR_FREE_PACKET   free_pkt;

    // Branch outcome is handled by the recovery path, not here.
    logic unused_take_branch;
    assign unused_take_branch = ir.rob_ir_packet.take_branch;

    // Retire decision: while a store waits for its ack the latched copy is
    // retired, so a flush of the live head never abandons a committed store.
    always_comb begin
        src_t        = ir.rob_ir_packet.retire_t;
        src_t_old    = ir.rob_ir_packet.retire_t_old;
        src_has_dest = ir.rob_ir_packet.has_dest_reg;
        src_inst     = ir.rob_ir_packet.inst;
        src_npc      = ir.rob_ir_packet.NPC;
        retire_now   = 1'b0;
        halt_now     = 1'b0;
        stall_now    = 1'b0;
        req_now      = 1'b0;
        if (state_reg == ST_WAIT) begin
            src_t        = lat_t_reg;
            src_t_old    = lat_t_old_reg;
            src_has_dest = lat_has_dest_reg;
            src_inst     = lat_inst_reg;
            src_npc      = lat_npc_reg;
        end
        if (!reset) begin
            unique case (state_reg)
                RUN: begin
                    if (ir.rob_ir_packet.retire_en) begin
                        if (ir.rob_ir_packet.halt) begin
                            retire_now = 1'b1;
                            halt_now   = 1'b1;
                        end else if (ir.rob_ir_packet.wr_mem) begin
                            req_now = 1'b1;
                            if (ir.st_commit_ack) begin
                                retire_now = 1'b1;
                            end else begin
                                stall_now = 1'b1;
                            end
                        end else begin
                            retire_now = 1'b1;
                        end
                    end
                end
                ST_WAIT: begin
                    req_now = 1'b1;
                    if (ir.st_commit_ack) begin
                        retire_now = 1'b1;
                    end else begin
                        stall_now = 1'b1;
                    end
                end
                HALTED: begin
                    stall_now = 1'b1;
                end
                default: begin
                    stall_now = 1'b0;
                end
            endcase
        end
    end

    // Register x0 is never remapped and its tag is never freed; halt has no
    // destination.
    always_comb begin
        amt_wr_idx        = src_inst[RD_LSB +: AW];
        amt_wr_en         = retire_now && !halt_now && src_has_dest &&
                            (amt_wr_idx != '0);
        free_pkt.free_en  = amt_wr_en;
        free_pkt.free_tag = amt_wr_en ? src_t_old : '0;
    end

    // FSM: capture a store that missed its ack, release it on ack, park on halt.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg        <= RUN;
            halted_reg       <= 1'b0;
            lat_t_reg        <= '0;
            lat_t_old_reg    <= '0;
            lat_has_dest_reg <= 1'b0;
            lat_inst_reg     <= '0;
            lat_npc_reg      <= '0;
        end else begin
            unique case (state_reg)
                RUN: begin
                    if (halt_now) begin
                        state_reg  <= HALTED;
                        halted_reg <= 1'b1;
                    end else if (req_now && !ir.st_commit_ack) begin
                        state_reg        <= ST_WAIT;
                        lat_t_reg        <= ir.rob_ir_packet.retire_t;
                        lat_t_old_reg    <= ir.rob_ir_packet.retire_t_old;
                        lat_has_dest_reg <= ir.rob_ir_packet.has_dest_reg;
                        lat_inst_reg     <= ir.rob_ir_packet.inst;
                        lat_npc_reg      <= ir.rob_ir_packet.NPC;
                    end
                end
                ST_WAIT: begin
                    if (ir.st_commit_ack) begin
                        state_reg <= RUN;
                    end
                end
                HALTED: begin
                    state_reg <= HALTED;
                end
                default: begin
                    state_reg <= RUN;
                end
            endcase
        end
    end

    // Retired-instruction counter, wraps naturally.
    always_ff @(posedge clock) begin
        if (reset) begin
            retired_cnt_reg <= '0;
        end else if (retire_now) begin
            retired_cnt_reg <= retired_cnt_reg + CNT_W'(1);
        end
    end

    arch_map_table #(
        .NUM_ARCH_REG (NUM_ARCH_REG)
    ) u_amt (
        .clock  (clock),
        .reset  (reset),
        .wr_en  (amt_wr_en),
        .wr_idx (amt_wr_idx),
        .wr_tag (src_t),
        .map    (arch_map)
    );

    assign ir.ir_stall      = stall_now;
    assign ir.st_commit_req = req_now;
    assign ir.retire_valid  = retire_now;
    assign ir.retire_NPC    = retire_now ? src_npc  : '0;
    assign ir.retire_inst   = retire_now ? src_inst : '0;
    assign ir.free_en       = free_pkt.free_en;
    assign ir.free_tag      = free_pkt.free_tag;
    assign halted           = halted_reg;
    assign retired_cnt      = retired_cnt_reg;

endmodule

// File: tb/tb_retire_stage.sv
// Bench for retire_stage: directed scenarios with literal expectations, then
// randomized heads/acks/resets checked every cycle against a queue-based model.
module tb_retire_stage;
    import retire_stage_pkg::*;

    localparam int NAR = 32;
    localparam int CW  = 64;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    retire_stage_if bus();
    TAG          arch_map [NAR];
    logic        halted;
    logic [CW-1:0] retired_cnt;

    retire_stage #(.NUM_ARCH_REG(NAR), .CNT_W(CW)) dut (
        .clock       (clock),
        .reset       (reset),
        .ir          (bus.slave),
        .arch_map    (arch_map),
        .halted      (halted),
        .retired_cnt (retired_cnt)
    );

    int checks = 0;
    int errors = 0;

    // Model state: architectural map, count, halt flag, store awaiting ack.
    TAG           m_amt [NAR];
    logic [CW-1:0] m_cnt;
    bit           m_halted;
    ROB_IR_PACKET m_pend[$];

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic ROB_IR_PACKET mk(bit en, TAG t, TAG told, logic [4:0] rd,
                                        bit hd, bit wm, bit hl, logic [31:0] npc);
        ROB_IR_PACKET p;
        p.retire_en    = en;
        p.retire_t     = t;
        p.retire_t_old = told;
        p.inst         = {20'h00abc, rd, 7'b0110011};
        p.halt         = hl;
        p.wr_mem       = wm;
        p.has_dest_reg = hd;
        p.NPC          = npc;
        p.take_branch  = 1'b0;
        return p;
    endfunction

    // Expected behaviour for one cycle, then advance the model across the edge.
    task automatic check_cycle();
        ROB_IR_PACKET p = bus.rob_ir_packet;
        ROB_IR_PACKET r = p;
        logic ack = bus.st_commit_ack;
        bit e_stall = 0, e_req = 0, do_ret = 0, is_halt = 0, fe;
        int bad = -1;
        logic [4:0] rd;

        for (int i = 0; i < NAR; i++) if (bad < 0 && arch_map[i] !== m_amt[i]) bad = i;
        if (bad < 0) chk("arch_map", 64'(arch_map[0]), 64'(m_amt[0]));
        else chk($sformatf("arch_map[%0d]", bad), 64'(arch_map[bad]), 64'(m_amt[bad]));
        chk("retired_cnt", retired_cnt, m_cnt);
        chk("halted", 64'(halted), 64'(m_halted));

        if (reset) begin
            // everything idle
        end else if (m_halted) begin
            e_stall = 1;
        end else if (m_pend.size() > 0) begin
            e_req = 1;
            if (ack) begin r = m_pend.pop_front(); do_ret = 1; end
            else e_stall = 1;
        end else if (p.retire_en) begin
            if (p.halt) begin do_ret = 1; is_halt = 1; end
            else if (p.wr_mem) begin
                e_req = 1;
                if (ack) do_ret = 1;
                else begin e_stall = 1; m_pend.push_back(p); end
            end else do_ret = 1;
        end

        rd = r.inst[11:7];
        fe = do_ret && !is_halt && r.has_dest_reg && (rd != 0);
        chk("ir_stall", 64'(bus.ir_stall), 64'(e_stall));
        chk("st_commit_req", 64'(bus.st_commit_req), 64'(e_req));
        chk("retire_valid", 64'(bus.retire_valid), 64'(do_ret));
        chk("free_en", 64'(bus.free_en), 64'(fe));
        if (fe) chk("free_tag", 64'(bus.free_tag), 64'(r.retire_t_old));
        if (do_ret) begin
            chk("retire_NPC", 64'(bus.retire_NPC), 64'(r.NPC));
            chk("retire_inst", 64'(bus.retire_inst), 64'(r.inst));
            $display("retire npc=%08h inst=%08h free=%0d tag=%0d cnt=%0d",
                     r.NPC, r.inst, fe, r.retire_t_old, m_cnt + 1);
            m_cnt = m_cnt + 1;
            if (fe) m_amt[rd] = r.retire_t;
            if (is_halt) m_halted = 1;
        end

        if (reset) begin
            for (int i = 0; i < NAR; i++) m_amt[i] = TAG'(i);
            m_cnt = '0;
            m_halted = 0;
            m_pend.delete();
        end
    endtask

    // Compare process: outputs sampled on the falling edge every cycle.
    initial begin
        for (int i = 0; i < NAR; i++) m_amt[i] = TAG'(i);
        m_cnt = '0;
        m_halted = 0;
        forever begin
            @(negedge clock);
            check_cycle();
        end
    end

    task automatic drive(ROB_IR_PACKET p, logic ack, logic rst);
        @(posedge clock);
        #1;
        bus.rob_ir_packet = p;
        bus.st_commit_ack = ack;
        reset = rst;
        #1;
    endtask

    initial begin
        ROB_IR_PACKET idle, st, junk, p;
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0);
        bus.rob_ir_packet = idle;
        bus.st_commit_ack = 1'b0;
        reset = 1'b1;
        drive(idle, 0, 1);
        drive(idle, 0, 0);
        chk("lit reset arch_map[5]", 64'(arch_map[5]), 64'd5);
        chk("lit reset cnt", retired_cnt, 64'd0);
        chk("lit reset halted", 64'(halted), 64'd0);
        chk("lit reset stall", 64'(bus.ir_stall), 64'd0);

        // Plain retire with a destination.
        drive(mk(1, 40, 3, 3, 1, 0, 0, 32'h10), 0, 0);
        chk("lit alu free_en", 64'(bus.free_en), 64'd1);
        chk("lit alu free_tag", 64'(bus.free_tag), 64'd3);
        chk("lit alu retire_valid", 64'(bus.retire_valid), 64'd1);
        chk("lit alu stall", 64'(bus.ir_stall), 64'd0);
        drive(idle, 0, 0);
        chk("lit alu arch_map[3]", 64'(arch_map[3]), 64'd40);
        chk("lit alu cnt", retired_cnt, 64'd1);

        // rd == 0: retires, but no free and no remap.
        drive(mk(1, 41, 7, 0, 1, 0, 0, 32'h14), 0, 0);
        chk("lit x0 retire_valid", 64'(bus.retire_valid), 64'd1);
        chk("lit x0 free_en", 64'(bus.free_en), 64'd0);
        drive(idle, 0, 0);
        chk("lit x0 arch_map[0]", 64'(arch_map[0]), 64'd0);
        chk("lit x0 cnt", retired_cnt, 64'd2);

        // Store with ack three cycles late.
        st = mk(1, 0, 0, 0, 0, 1, 0, 32'h100);
        for (int k = 0; k < 4; k++) begin
            drive(st, (k == 3), 0);
            chk($sformatf("lit st req c%0d", k), 64'(bus.st_commit_req), 64'd1);
            chk($sformatf("lit st stall c%0d", k), 64'(bus.ir_stall), 64'(k < 3));
            chk($sformatf("lit st retire c%0d", k), 64'(bus.retire_valid), 64'(k == 3));
        end
        drive(idle, 0, 0);
        chk("lit st req after", 64'(bus.st_commit_req), 64'd0);
        chk("lit st cnt", retired_cnt, 64'd3);

        // Store acked in the same cycle.
        drive(mk(1, 0, 0, 0, 0, 1, 0, 32'h104), 1, 0);
        chk("lit st0 req", 64'(bus.st_commit_req), 64'd1);
        chk("lit st0 stall", 64'(bus.ir_stall), 64'd0);
        chk("lit st0 retire", 64'(bus.retire_valid), 64'd1);
        drive(idle, 0, 0);
        chk("lit st0 still run", 64'(bus.st_commit_req), 64'd0);
        chk("lit st0 cnt", retired_cnt, 64'd4);

        // Store waits, head is flushed, ack arrives two cycles later.
        drive(mk(1, 0, 0, 0, 0, 1, 0, 32'h200), 0, 0);
        chk("lit fl stall", 64'(bus.ir_stall), 64'd1);
        junk = mk(0, 9, 9, 9, 1, 0, 0, 32'h999);
        drive(junk, 0, 0);
        chk("lit fl req", 64'(bus.st_commit_req), 64'd1);
        chk("lit fl no retire", 64'(bus.retire_valid), 64'd0);
        drive(junk, 1, 0);
        chk("lit fl retire", 64'(bus.retire_valid), 64'd1);
        chk("lit fl npc", 64'(bus.retire_NPC), 64'h200);
        chk("lit fl stall off", 64'(bus.ir_stall), 64'd0);
        drive(idle, 0, 0);
        chk("lit fl no second req", 64'(bus.st_commit_req), 64'd0);
        chk("lit fl cnt", retired_cnt, 64'd5);

        // Halt.
        drive(mk(1, 0, 0, 0, 0, 0, 1, 32'h300), 0, 0);
        chk("lit halt retire", 64'(bus.retire_valid), 64'd1);
        drive(mk(1, 50, 9, 9, 1, 0, 0, 32'h304), 0, 0);
        chk("lit halt halted", 64'(halted), 64'd1);
        chk("lit halt cnt", retired_cnt, 64'd6);
        chk("lit halt stall", 64'(bus.ir_stall), 64'd1);
        chk("lit halt no retire", 64'(bus.retire_valid), 64'd0);
        drive(mk(1, 0, 0, 0, 0, 1, 0, 32'h308), 1, 0);
        chk("lit halt no req", 64'(bus.st_commit_req), 64'd0);
        drive(idle, 0, 1);
        drive(idle, 0, 0);
        chk("lit halt cleared", 64'(halted), 64'd0);
        chk("lit halt cnt cleared", retired_cnt, 64'd0);
        chk("lit halt amt[3]", 64'(arch_map[3]), 64'd3);

        // Randomized heads, acks and occasional resets.
        for (int n = 0; n < 3000; n++) begin
            bit wm;
            wm = ($urandom_range(0, 3) == 0);
            p = mk(($urandom_range(0, 3) != 0), TAG'($urandom), TAG'($urandom),
                   5'($urandom), 1'($urandom), wm,
                   (!wm && ($urandom_range(0, 149) == 0)), $urandom);
            p.take_branch = 1'($urandom);
            drive(p, ($urandom_range(0, 2) == 0), ($urandom_range(0, 99) == 0));
        end
        drive(idle, 0, 0);
        repeat (2) @(posedge clock);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
